frame_capture_ctrl: RTL and testbench

Sequences capture of OV7670 RGB565 pixel data into the 176x144 RGB332 M9K frame buffer. It sits between the camera GPIO inputs and the write port of the dual-port RAM. It oversamples PCLK/HREF/VSYNC in the 50 MHz write-clock domain, pairs bytes, downsamples and generates a linear write address. It arms on request, captures only whole frames, and reports frame completion, line count and overrun to the image processor and top level.

---
 rtl/frame_capture_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// OV7670 RGB565 byte stream -> RGB332 frame-buffer write sequencer (whole frames only).
// Define CAPTURE_TEST_PATTERN_EN to replace camera pixels with colour bars indexed by X[7:5].
module frame_capture_ctrl #(
   parameter int SCREEN_WIDTH  = 176,
   parameter int SCREEN_HEIGHT = 144,
   parameter int ADDR_W        = 15
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              PCLK,
   input  logic              HREF,
   input  logic              VSYNC,
   input  logic [7:0]        CAM_DATA,
   input  logic              CAPTURE_EN,
   output logic              W_EN,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        W_DATA,
   output logic              FRAME_DONE,
   output logic              BUSY,
   output logic [7:0]        LINE_COUNT,
   output logic              OVERRUN,
   output logic [7:0]        FRAME_COUNT
);
   typedef enum logic [2:0] {IDLE, ARM, WAIT_VS, ACTIVE, DONE} state_t;

   localparam logic [8:0]        X_LIM     = 9'(SCREEN_WIDTH);
   localparam logic [7:0]        Y_LIM     = 8'(SCREEN_HEIGHT);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

   state_t state_reg, state_next;

   // {PCLK, HREF, VSYNC, CAM_DATA} travel together so data stays aligned with its PCLK edge
   logic [10:0] sync1_reg, sync2_reg, hist_reg;
   logic        href_s, vsync_s, pclk_rise, href_fall, vsync_rise, vsync_fall;
   logic [7:0]  data_s;

   logic [8:0]        x_reg, x_next;
   logic [7:0]        y_reg, y_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic              phase_reg, phase_next;
   logic [5:0]        hi_reg, hi_next;
   logic              w_en_reg, w_en_next;
   logic [ADDR_W-1:0] w_addr_reg, w_addr_next;
   logic [7:0]        w_data_reg, w_data_next;
   logic              frame_done_reg, frame_done_next;
   logic              busy_reg, busy_next;
   logic [7:0]        line_count_reg, line_count_next;
   logic              overrun_reg, overrun_next;
   logic [7:0]        frame_count_reg, frame_count_next;
   logic [7:0]        pix;

   assign href_s     = sync2_reg[9];
   assign vsync_s    = sync2_reg[8];
   assign data_s     = sync2_reg[7:0];
   assign pclk_rise  = sync2_reg[10] & ~hist_reg[10];
   assign href_fall  = ~sync2_reg[9] & hist_reg[9];
   assign vsync_rise = sync2_reg[8] & ~hist_reg[8];
   assign vsync_fall = ~sync2_reg[8] & hist_reg[8];

`ifdef CAPTURE_TEST_PATTERN_EN
   always_comb begin
      case (x_reg[7:5])
         3'd0:    pix = 8'hE0;
         3'd1:    pix = 8'h1C;
         3'd2:    pix = 8'h03;
         3'd3:    pix = 8'hFF;
         3'd5:    pix = 8'hFC;
         default: pix = 8'h00;
      endcase
   end
`else
   assign pix = {hi_reg, data_s[4:3]};
`endif

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg       <= IDLE;
         sync1_reg       <= '0;
         sync2_reg       <= '0;
         hist_reg        <= '0;
         x_reg           <= '0;
         y_reg           <= '0;
         base_reg        <= '0;
         phase_reg       <= 1'b0;
         hi_reg          <= '0;
         w_en_reg        <= 1'b0;
         w_addr_reg      <= '0;
         w_data_reg      <= '0;
         frame_done_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         line_count_reg  <= '0;
         overrun_reg     <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         sync1_reg       <= {PCLK, HREF, VSYNC, CAM_DATA};
         sync2_reg       <= sync1_reg;
         hist_reg        <= sync2_reg;
         x_reg           <= x_next;
         y_reg           <= y_next;
         base_reg        <= base_next;
         phase_reg       <= phase_next;
         hi_reg          <= hi_next;
         w_en_reg        <= w_en_next;
         w_addr_reg      <= w_addr_next;
         w_data_reg      <= w_data_next;
         frame_done_reg  <= frame_done_next;
         busy_reg        <= busy_next;
         line_count_reg  <= line_count_next;
         overrun_reg     <= overrun_next;
         frame_count_reg <= frame_count_next;
      end
   end

   // ARM demands VSYNC high before WAIT_VS so a frame is never joined mid-way
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (CAPTURE_EN) state_next = ARM;
         ARM:     if (vsync_s) state_next = WAIT_VS;
         WAIT_VS: if (vsync_fall) state_next = ACTIVE;
         ACTIVE:  if (vsync_rise) state_next = DONE;
         DONE:    state_next = CAPTURE_EN ? ARM : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      x_next           = x_reg;
      y_next           = y_reg;
      base_next        = base_reg;
      phase_next       = phase_reg;
      hi_next          = hi_reg;
      w_en_next        = 1'b0;
      w_addr_next      = w_addr_reg;
      w_data_next      = w_data_reg;
      frame_done_next  = 1'b0;
      busy_next        = (state_next != IDLE);
      line_count_next  = line_count_reg;
      overrun_next     = overrun_reg;
      frame_count_next = frame_count_reg;
      case (state_reg)
         WAIT_VS: begin
            if (vsync_fall) begin
               x_next       = '0;
               y_next       = '0;
               base_next    = '0;
               phase_next   = 1'b0;
               overrun_next = 1'b0;
            end
         end
         ACTIVE: begin
            if (pclk_rise && href_s) begin
               if (!phase_reg) begin
                  hi_next    = {data_s[7:5], data_s[2:0]};
                  phase_next = 1'b1;
               end else begin
                  phase_next = 1'b0;
                  if (x_reg != '1) x_next = x_reg + 9'd1;
                  if (x_reg < X_LIM && y_reg < Y_LIM) begin
                     w_en_next   = 1'b1;
                     w_addr_next = base_reg + ADDR_W'(x_reg);
                     w_data_next = pix;
                  end else begin
                     overrun_next = 1'b1;
                  end
               end
            end else if (href_fall) begin
               // a dangling high byte is dropped; empty lines do not advance Y
               phase_next = 1'b0;
               x_next     = '0;
               if (x_reg != '0) begin
                  if (y_reg != '1) y_next = y_reg + 8'd1;
                  if (y_reg < Y_LIM) base_next = base_reg + LINE_STEP;
               end
            end
         end
         DONE: begin
            frame_done_next  = 1'b1;
            line_count_next  = y_reg;
            frame_count_next = frame_count_reg + 8'd1;
         end
         default: ;
      endcase
   end

   assign W_EN        = w_en_reg;
   assign W_ADDR      = w_addr_reg;
   assign W_DATA      = w_data_reg;
   assign FRAME_DONE  = frame_done_reg;
   assign BUSY        = busy_reg;
   assign LINE_COUNT  = line_count_reg;
   assign OVERRUN     = overrun_reg;
   assign FRAME_COUNT = frame_count_reg;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: randomized camera bytes, frame-level reference model of
// expected writes, frame status and latencies.
module tb_frame_capture_ctrl;
   localparam int W = 176;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pclk = 1'b0, href = 1'b0, vsync = 1'b0, cap_en = 1'b0;
   logic [7:0]  cam_data = 8'h00;
   logic        w_en, frame_done, busy, overrun;
   logic [14:0] w_addr;
   logic [7:0]  w_data, line_count, frame_count;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  cyc = 0;
   int  n_assert = 0, n_fail = 0;
   int  fd_cnt = 0, fd_cyc = 0, fd_line = 0, fd_frame = 0;
   int  exp_fd = 0, exp_frames = 0, m_y = 0;
   bit  m_ovr = 1'b0;

   frame_capture_ctrl #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(15)) dut (
      .CLK(clk), .RESET_N(rst_n), .PCLK(pclk), .HREF(href), .VSYNC(vsync),
      .CAM_DATA(cam_data), .CAPTURE_EN(cap_en), .W_EN(w_en), .W_ADDR(w_addr),
      .W_DATA(w_data), .FRAME_DONE(frame_done), .BUSY(busy), .LINE_COUNT(line_count),
      .OVERRUN(overrun), .FRAME_COUNT(frame_count)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      wr_t o;
      if (w_en === 1'b1) begin
         o.addr = int'(w_addr);
         o.data = int'(w_data);
         o.cyc  = cyc;
         obs_q.push_back(o);
      end
      if (frame_done === 1'b1) begin
         fd_cnt++;
         fd_cyc   = cyc;
         fd_line  = int'(line_count);
         fd_frame = int'(frame_count);
      end
   end

   function automatic int exp_pix(input int p, input int hi, input int lo);
`ifdef CAPTURE_TEST_PATTERN_EN
      case (p / 32)
         0: return 'hE0;
         1: return 'h1C;
         2: return 'h03;
         3: return 'hFF;
         5: return 'hFC;
         default: return 'h00;
      endcase
`else
      return ((hi / 32) * 32) + ((hi % 8) * 4) + ((lo / 8) % 4);
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_w_en"}, 32'(w_en), 0);
      check({tag, "_w_addr"}, 32'(w_addr), 0);
      check({tag, "_w_data"}, 32'(w_data), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_line_count"}, 32'(line_count), 0);
      check({tag, "_overrun"}, 32'(overrun), 0);
      check({tag, "_frame_count"}, 32'(frame_count), 0);
   endtask

   task automatic check_writes(input string tag);
      int n;
      int f0;
      int lat;
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      check({tag, "_write_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < n; i++) begin
         f0 = n_fail;
         check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
         check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
         lat = obs_q[i].cyc - exp_q[i].cyc;
         n_assert++;
         assert (lat >= 3 && lat <= 5) else begin
            n_fail++;
            $error("FAIL %s_latency: observed %0d cycles expected 3..5", tag, lat);
         end
         if (n_fail != f0) break;
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, output int rise_cyc);
      cam_data = b;
      pclk = 1'b0;
      tick(2);
      pclk = 1'b1;
      rise_cyc = cyc;
      tick(2);
      pclk = 1'b0;
   endtask

   // cap: this line belongs to a frame the DUT should capture; close: drop HREF at the end
   task automatic send_line(input int nbytes, input bit rnd, input bit cap, input bit close);
      int hi = 0;
      int rc;
      logic [7:0] b;
      wr_t e;
      href = 1'b1;
      tick(2);
      for (int i = 0; i < nbytes; i++) begin
         b = rnd ? 8'($urandom) : ((i % 2 == 0) ? 8'hF8 : 8'h1F);
         send_byte(b, rc);
         if (i % 2 == 0) begin
            hi = int'(b);
         end else if (cap) begin
            if (i / 2 < W && m_y < H) begin
               e.addr = m_y * W + i / 2;
               e.data = exp_pix(i / 2, hi, int'(b));
               e.cyc  = rc;
               exp_q.push_back(e);
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
      if (close) begin
         tick(2);
         href = 1'b0;
         tick(6);
         if (cap && nbytes >= 2) m_y++;
      end else begin
         tick(4);
      end
   endtask

   task automatic start_frame(input bit cap);
      vsync = 1'b1;
      tick(8);
      vsync = 1'b0;
      tick(8);
      if (cap) begin
         m_y   = 0;
         m_ovr = 1'b0;
      end
   endtask

   task automatic end_frame(input string tag, input bit cap);
      int t;
      vsync = 1'b1;
      t = cyc;
      tick(10);
      if (cap) begin
         exp_fd++;
         exp_frames = (exp_frames + 1) % 256;
      end
      check_writes(tag);
      check({tag, "_frame_done_pulses"}, fd_cnt, exp_fd);
      if (cap) begin
         check({tag, "_line_count"}, fd_line, (m_y > 255) ? 255 : m_y);
         check({tag, "_frame_count_at_done"}, fd_frame, exp_frames);
         check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
         n_assert++;
         assert (fd_cyc - t >= 3 && fd_cyc - t <= 5) else begin
            n_fail++;
            $error("FAIL %s_done_latency: observed %0d cycles expected 3..5", tag, fd_cyc - t);
         end
      end
      check({tag, "_frame_count"}, 32'(frame_count), exp_frames);
   endtask

   initial begin
      tick(3);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      tick(3);
      check("busy_idle", 32'(busy), 0);

      // capture requested mid-frame: nothing written until a full VSYNC high->low
      cap_en = 1'b1;
      tick(3);
      check("busy_armed", 32'(busy), 1);
      send_line(40, 1'b1, 1'b0, 1'b1);
      send_line(40, 1'b1, 1'b0, 1'b1);
      end_frame("midframe", 1'b0);

      start_frame(1'b1);
      repeat (H) send_line(2 * W, 1'b0, 1'b1, 1'b1);
      end_frame("full_fixed", 1'b1);

      // long line, odd byte count, empty line, single byte line
      start_frame(1'b1);
      send_line(360, 1'b1, 1'b1, 1'b1);
      send_line(7, 1'b1, 1'b1, 1'b1);
      send_line(0, 1'b1, 1'b1, 1'b1);
      send_line(2 * W, 1'b1, 1'b1, 1'b1);
      send_line(1, 1'b1, 1'b1, 1'b1);
      send_line(20, 1'b1, 1'b1, 1'b1);
      end_frame("odd_lines", 1'b1);

      // too many lines, capture dropped mid-frame: frame still completes
      start_frame(1'b1);
      repeat (4) send_line(10, 1'b1, 1'b1, 1'b1);
      cap_en = 1'b0;
      repeat (4) send_line(10, 1'b1, 1'b1, 1'b1);
      end_frame("extra_lines", 1'b1);
      check("busy_after_stop", 32'(busy), 0);
      start_frame(1'b0);
      send_line(20, 1'b1, 1'b0, 1'b1);
      end_frame("stopped", 1'b0);

      // reset in the middle of a line
      cap_en = 1'b1;
      start_frame(1'b1);
      send_line(10, 1'b1, 1'b1, 1'b0);
      check_writes("pre_reset");
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midline_reset");
      tick(2);
      rst_n = 1'b1;
      exp_frames = 0;
      send_line(20, 1'b1, 1'b0, 1'b1);
      send_line(40, 1'b1, 1'b0, 1'b1);
      check_writes("post_reset");
      start_frame(1'b1);
      send_line(2 * W, 1'b1, 1'b1, 1'b1);
      send_line(2 * W, 1'b1, 1'b1, 1'b1);
      end_frame("after_reset", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
